// File: rtl/data_memory_ws_pkg.sv
// Shared types and helpers for the wait-state data memory.
// Also holds the address-range check used by the top level.
package data_mem_pkg;

    typedef enum logic [1:0] {CLEAR, IDLE, READ_WAIT} state_t;

    localparam int DATA_W_DEF = 32;
    localparam int BE_W       = DATA_W_DEF / 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A word address is valid only when every bit above the index field is zero.
    function automatic logic in_range(input logic [63:0] addr, input int idx_w);
        return (addr >> idx_w) == 64'd0;
    endfunction

endpackage

// File: rtl/data_memory_ws_word_array.sv
// DEPTH x DATA_W storage with one byte-enabled write port and a clear port.
// Reads are combinational and see a same-edge write to the same word.
module dm_word_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  clr,
    input  logic [IDX_W-1:0]      clr_idx,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_W-1:0]     rdata
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear wins over a write so a partially cleared array never holds new data.
    always_ff @(posedge clk) begin
        if (clr) begin
            mem[clr_idx] <= '0;
        end else if (we) begin
            for (int b = 0; b < NB; b++)
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_comb begin
        rdata = mem[raddr];
        if (we && !clr && waddr == raddr) begin
            for (int b = 0; b < NB; b++)
                if (be[b]) rdata[8*b +: 8] = wdata[8*b +: 8];
        end
    end

endmodule

// File: rtl/data_memory_ws.sv
// Word-addressed data memory for the MEM stage: byte-enable writes, configurable
// read wait states, post-reset clear sequence and out-of-range detection.
module data_memory_ws
    import data_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 256,
    parameter int WAIT_STATES    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [ADDR_W-1:0]     write_address,
    input  logic [ADDR_W-1:0]     read_address,
    input  logic [DATA_W-1:0]     Write_data,
    input  logic [DATA_W/8-1:0]   byte_en,
    output logic [DATA_W-1:0]     MemData_out,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  addr_err
);
    localparam int               IDX_W    = clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [3:0]       WS       = 4'(WAIT_STATES);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  clear_idx, r_idx, rd_idx;
    logic [3:0]        wait_cnt;
    logic              r_oor, rd_oor, wr_oor;
    logic              wr_ok, wr_en, clr_en, rd_accept, rd_done;
    logic [DATA_W-1:0] rd_data;

    assign wr_ok     = reset && state != CLEAR && MemWrite;
    assign wr_oor    = !in_range(64'(write_address), IDX_W);
    assign wr_en     = wr_ok && !wr_oor;
    assign clr_en    = reset && state == CLEAR;
    assign rd_accept = reset && state == IDLE && MemRead;
    // Completion edge: immediately for zero wait states, else when the counter would reach 0.
    assign rd_done   = (rd_accept && WAIT_STATES == 0) ||
                       (reset && state == READ_WAIT && wait_cnt == 4'd1);
    assign rd_idx    = (state == IDLE) ? read_address[IDX_W-1:0] : r_idx;
    assign rd_oor    = (state == IDLE) ? !in_range(64'(read_address), IDX_W) : r_oor;

    dm_word_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk     (clk),
        .we      (wr_en),
        .waddr   (write_address[IDX_W-1:0]),
        .wdata   (Write_data),
        .be      (byte_en),
        .clr     (clr_en),
        .clr_idx (clear_idx),
        .raddr   (rd_idx),
        .rdata   (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:     if (clear_idx == LAST_IDX) state_nxt = IDLE;
            IDLE:      if (rd_accept && WAIT_STATES != 0) state_nxt = READ_WAIT;
            READ_WAIT: if (wait_cnt == 4'd1) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = !reset || state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clear_idx   <= '0;
            wait_cnt    <= '0;
            r_idx       <= '0;
            r_oor       <= 1'b0;
            MemData_out <= '0;
            rd_valid    <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            rd_valid <= rd_done;
            addr_err <= (rd_done && rd_oor) || (wr_ok && wr_oor);
            if (rd_done) MemData_out <= rd_oor ? '0 : rd_data;
            if (state == CLEAR) clear_idx <= clear_idx + IDX_W'(1);
            if (rd_accept) begin
                r_idx    <= rd_idx;
                r_oor    <= rd_oor;
                wait_cnt <= WS;
            end else if (state == READ_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: one instance with zero wait states, one with three.
// Expected read results go into per-instance queues and are checked as rd_valid fires.
module tb_data_memory_ws;
    import data_mem_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, wr_a, rd_a, rst_b, wr_b, rd_b;
    logic [31:0] wa_a, ra_a, wd_a, wa_b, ra_b, wd_b;
    logic [3:0]  be_a, be_b;
    logic [31:0] mo_a, mo_b;
    logic        rv_a, bz_a, ae_a, rv_b, bz_b, ae_b;

    exp_t qa[$];
    exp_t qb[$];
    int   total  = 0;
    int   passed = 0;

    data_memory_ws #(.WAIT_STATES(0)) dut_a (
        .clk(clk), .reset(rst_a), .MemWrite(wr_a), .MemRead(rd_a),
        .write_address(wa_a), .read_address(ra_a), .Write_data(wd_a), .byte_en(be_a),
        .MemData_out(mo_a), .rd_valid(rv_a), .busy(bz_a), .addr_err(ae_a)
    );

    data_memory_ws #(.WAIT_STATES(3)) dut_b (
        .clk(clk), .reset(rst_b), .MemWrite(wr_b), .MemRead(rd_b),
        .write_address(wa_b), .read_address(ra_b), .Write_data(wd_b), .byte_en(be_b),
        .MemData_out(mo_b), .rd_valid(rv_b), .busy(bz_b), .addr_err(ae_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rd_valid pops one expectation; rd_valid with nothing queued is an error.
    always @(negedge clk) begin
        exp_t e;
        if (rv_a === 1'b1) begin
            if (qa.size() == 0) chk("a_unexpected_rd_valid", 32'(rv_a), 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_rd_data", mo_a, e.data);
                chk("a_rd_err", 32'(ae_a), 32'(e.err));
            end
        end
        if (rv_b === 1'b1) begin
            if (qb.size() == 0) chk("b_unexpected_rd_valid", 32'(rv_b), 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_rd_data", mo_b, e.data);
                chk("b_rd_err", 32'(ae_b), 32'(e.err));
            end
        end
    end

    task automatic write_a(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        wr_a = 1'b1; wa_a = addr; wd_a = data; be_a = be;
        step(1);
        wr_a = 1'b0;
    endtask

    task automatic read_a(input logic [31:0] addr, input logic [31:0] data, input logic err);
        rd_a = 1'b1; ra_a = addr;
        qa.push_back('{data: data, err: err});
        step(1);
        rd_a = 1'b0;
    endtask

    task automatic write_b(input logic [31:0] addr, input logic [31:0] data);
        wr_b = 1'b1; wa_b = addr; wd_b = data; be_b = 4'hF;
        step(1);
        wr_b = 1'b0;
    endtask

    initial begin
        int ca, cb;
        rst_a = 0; wr_a = 0; rd_a = 0; wa_a = 0; ra_a = 0; wd_a = 0; be_a = 0;
        rst_b = 0; wr_b = 0; rd_b = 0; wa_b = 0; ra_b = 0; wd_b = 0; be_b = 0;

        // Reset state, then the clear phase must last exactly DEPTH cycles.
        step(2);
        @(negedge clk);
        chk("reset_busy", 32'(bz_a), 32'd1);
        chk("reset_rd_valid", 32'(rv_a), 32'd0);
        chk("reset_addr_err", 32'(ae_a), 32'd0);
        chk("reset_data", mo_a, 32'd0);
        @(posedge clk); #1;
        rst_a = 1; rst_b = 1;
        ca = 0; cb = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bz_a) ca++;
            if (bz_b) cb++;
        end
        chk("a_clear_cycles", 32'(ca), 32'd256);
        chk("b_clear_cycles", 32'(cb), 32'd256);
        step(1);

        // Cleared contents, back-to-back single-cycle reads.
        read_a(32'd0, 32'd0, 1'b0);
        read_a(32'd3, 32'd0, 1'b0);
        read_a(32'd255, 32'd0, 1'b0);
        step(2);

        write_a(32'd3, 32'hFFFF_FFFF, 4'hF);
        read_a(32'd3, 32'hFFFF_FFFF, 1'b0);
        step(2);

        // Partial write on the same edge as a read of that word is merged into the read.
        write_a(32'd5, 32'h1122_3344, 4'hF);
        wr_a = 1; wa_a = 32'd5; wd_a = 32'hAABB_CCDD; be_a = 4'b0101;
        read_a(32'd5, 32'h11BB_33DD, 1'b0);
        wr_a = 0;
        write_a(32'd5, 32'h0000_0000, 4'h0);
        read_a(32'd5, 32'h11BB_33DD, 1'b0);
        step(2);

        // Out-of-range write is dropped and pulses addr_err for one cycle.
        write_a(32'h100, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        chk("a_wr_oor_err", 32'(ae_a), 32'd1);
        step(1);
        @(negedge clk);
        chk("a_wr_oor_err_drop", 32'(ae_a), 32'd0);
        step(1);
        read_a(32'd0, 32'd0, 1'b0);
        read_a(32'hFFFF_FFFF, 32'd0, 1'b1);
        step(2);
        @(negedge clk);
        chk("a_err_cleared", 32'(ae_a), 32'd0);
        step(1);

        // Three wait states: busy for 3 cycles, ignored read, write during the wait.
        write_b(32'd7, 32'h0000_BEEF);
        rd_b = 1; ra_b = 32'd7;
        qb.push_back('{data: 32'h0000_1234, err: 1'b0});
        step(1);
        ra_b = 32'd8;
        @(negedge clk);
        chk("b_wait1_busy", 32'(bz_b), 32'd1);
        chk("b_wait1_rd_valid", 32'(rv_b), 32'd0);
        step(1);
        wr_b = 1; wa_b = 32'd7; wd_b = 32'h0000_1234; be_b = 4'hF;
        @(negedge clk);
        chk("b_wait2_busy", 32'(bz_b), 32'd1);
        step(1);
        wr_b = 0;
        @(negedge clk);
        chk("b_wait3_busy", 32'(bz_b), 32'd1);
        chk("b_wait3_rd_valid", 32'(rv_b), 32'd0);
        step(1);
        rd_b = 0;
        @(negedge clk);
        chk("b_done_busy", 32'(bz_b), 32'd0);
        chk("b_done_rd_valid", 32'(rv_b), 32'd1);
        step(8);

        // Reset during a wait drops the read and restarts the clear.
        write_b(32'd9, 32'h0000_CAFE);
        rd_b = 1; ra_b = 32'd9;
        step(1);
        rd_b = 0; rst_b = 0;
        step(2);
        @(negedge clk);
        chk("b_rst_data", mo_b, 32'd0);
        chk("b_rst_busy", 32'(bz_b), 32'd1);
        chk("b_rst_rd_valid", 32'(rv_b), 32'd0);
        @(posedge clk); #1;
        rst_b = 1;
        cb = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bz_b) cb++;
        end
        chk("b_reclear_cycles", 32'(cb), 32'd256);
        step(1);
        rd_b = 1; ra_b = 32'd9;
        qb.push_back('{data: 32'd0, err: 1'b0});
        step(1);
        rd_b = 0;
        step(8);

        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
